// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding and the clogb2 sizing helper.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  // Number of bits needed to hold the value itself, so clogb2(4)=3 and an
  // out-of-range slave index such as 5 is still expressible on cs_sel.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int v = value; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCLK timing: DIV-cycle half-period tick plus leading/trailing edge strobes, active only while en=1.
module spi_clkgen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick,
  output logic lead,
  output logic trail,
  output logic phase
);

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  logic [7:0] div_cnt;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // phase=0 means sclk sits at its idle level, so the next tick is a leading edge.
  assign tick  = en && (div_cnt == DIV_LAST);
  assign lead  = tick && !phase;
  assign trail = tick && phase;

endmodule

// File: rtl/spi_master_mc.sv
// Multi-slave SPI master with run-time CPOL/CPHA and slave select.
// Optional macro SPI_LSB_FIRST_EN adds the lsb_first input (LSB-first framing).
module spi_master_mc
  import spi_pkg::*;
#(
  parameter int BITS = 8,
  parameter int NSS  = 4,
  parameter int DIV  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     cpol,
  input  logic                     cpha,
  input  logic [clogb2(NSS)-1:0]   cs_sel,
  input  logic [BITS-1:0]          tx_data,
`ifdef SPI_LSB_FIRST_EN
  input  logic                     lsb_first,
`endif
  input  logic                     miso,
  output logic                     sclk,
  output logic                     mosi,
  output logic [NSS-1:0]           ss_n,
  output logic                     busy,
  output logic                     done,
  output logic [BITS-1:0]          rx_data
);

  localparam int         CSW      = clogb2(NSS);
  localparam int         HW       = clogb2(BITS) + 1;
  localparam logic [7:0] CNT_LAST = 8'(DIV - 1);
  localparam logic [HW-1:0] H_LAST = HW'(2 * BITS - 1);

  spi_state_e      state_q, state_d;
  logic [7:0]      cnt;
  logic [HW-1:0]   hcnt;
  logic [BITS-1:0] tx_sh, rx_sh;
  logic [CSW-1:0]  cs_q;
  logic            cpol_q, cpha_q;
  logic            tick, lead, trail, phase;
  logic            accept, out_evt, in_evt;
  logic            lsb_in, lsb_q;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         lsb_q <= 1'b0;
    else if (accept) lsb_q <= lsb_first;
  end
`else
  assign lsb_in = 1'b0;
  assign lsb_q  = 1'b0;
`endif

  spi_clkgen #(.DIV(DIV)) u_clkgen (
    .clk   (clk),
    .rst   (rst),
    .en    (state_q == ST_XFER),
    .tick  (tick),
    .lead  (lead),
    .trail (trail),
    .phase (phase)
  );

  assign accept  = (state_q == ST_IDLE) && start;
  assign out_evt = cpha_q ? lead : trail;
  assign in_evt  = cpha_q ? trail : lead;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SETUP;
      ST_SETUP: if (cnt == CNT_LAST) state_d = ST_XFER;
      ST_XFER:  if (tick && hcnt == H_LAST) state_d = ST_HOLD;
      ST_HOLD:  if (cnt == CNT_LAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      hcnt    <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      cs_q    <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      mosi    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
    end else begin
      done <= 1'b0;
      if (state_d != state_q) cnt <= '0;
      else if (state_q == ST_SETUP || state_q == ST_HOLD) cnt <= cnt + 1'b1;

      if (accept) begin
        cpol_q <= cpol;
        cpha_q <= cpha;
        cs_q   <= cs_sel;
        hcnt   <= '0;
        rx_sh  <= '0;
        // CPHA=0 must show the first bit before the first leading edge.
        if (!cpha) begin
          mosi  <= lsb_in ? tx_data[0] : tx_data[BITS-1];
          tx_sh <= lsb_in ? (tx_data >> 1) : (tx_data << 1);
        end else begin
          mosi  <= 1'b0;
          tx_sh <= tx_data;
        end
      end

      if (state_q == ST_XFER) begin
        if (tick) hcnt <= hcnt + 1'b1;
        if (out_evt) begin
          mosi  <= lsb_q ? tx_sh[0] : tx_sh[BITS-1];
          tx_sh <= lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
        end
        if (in_evt) rx_sh <= lsb_q ? {miso, rx_sh[BITS-1:1]} : {rx_sh[BITS-2:0], miso};
      end

      if (state_q == ST_HOLD && state_d == ST_IDLE) begin
        done    <= 1'b1;
        rx_data <= rx_sh;
        mosi    <= 1'b0;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign sclk = cpol_q ^ phase;

  always_comb begin
    ss_n = '1;
    if (busy) begin
      for (int i = 0; i < NSS; i++) begin
        if (cs_q == CSW'(i)) ss_n[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_mc.sv
// Self-checking bench for spi_master_mc: table vectors, random frames, back-to-back and reset-abort sequences.
module tb_spi_master_mc;
  import spi_pkg::*;

  localparam int BITS = 8;
  localparam int NSS  = 4;
  localparam int DIV  = 2;
  localparam int CSW  = clogb2(NSS);

  typedef struct {
    logic [BITS-1:0] tx;
    logic            cpol;
    logic            cpha;
    logic [CSW-1:0]  cs;
    logic            loop;
    logic            lsb;
    logic [BITS-1:0] slave;
    logic [BITS-1:0] exp_rx;
    logic [NSS-1:0]  exp_ss;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start, cpol, cpha, lsb_first, loop_mode, miso_drv, miso;
  logic [CSW-1:0]  cs_sel;
  logic [BITS-1:0] tx_data;
  logic            sclk, mosi, busy, done;
  logic [NSS-1:0]  ss_n;
  logic [BITS-1:0] rx_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign miso = loop_mode ? mosi : miso_drv;

  spi_master_mc #(.BITS(BITS), .NSS(NSS), .DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cpol      (cpol),
    .cpha      (cpha),
    .cs_sel    (cs_sel),
    .tx_data   (tx_data),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first (lsb_first),
`endif
    .miso      (miso),
    .sclk      (sclk),
    .mosi      (mosi),
    .ss_n      (ss_n),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference rules: only an in-range index drops its select line.
  function automatic logic [NSS-1:0] ss_model(input logic [CSW-1:0] cs);
    logic [NSS-1:0] r;
    r = '1;
    if (int'(cs) < NSS) r[cs] = 1'b0;
    return r;
  endfunction

  function automatic logic slave_bit(input logic [BITS-1:0] w, input logic lsb, input int k);
    if (k >= BITS) return 1'b0;
    return lsb ? w[k] : w[BITS-1-k];
  endfunction

  function automatic vec_t mk(input logic [BITS-1:0] tx, input logic pol, input logic pha,
                              input logic [CSW-1:0] cs, input logic lp, input logic lsb,
                              input logic [BITS-1:0] slv);
    vec_t v;
    v.tx = tx; v.cpol = pol; v.cpha = pha; v.cs = cs; v.loop = lp; v.lsb = lsb; v.slave = slv;
    v.exp_rx = lp ? tx : slv;
    v.exp_ss = ss_model(cs);
    return v;
  endfunction

  task automatic run_frame(input vec_t v, input string tag);
    int cyc, toggles, busy_cyc, last_tog, bad_int, bad_ss, samples;
    logic [BITS-1:0] mosi_word;
    logic prev_sclk, sample_edge;
    cyc = 0; toggles = 0; busy_cyc = 0; last_tog = DIV; bad_int = 0; bad_ss = 0; samples = 0;
    mosi_word = '0;
    @(negedge clk);
    tx_data = v.tx; cpol = v.cpol; cpha = v.cpha; cs_sel = v.cs;
    loop_mode = v.loop; lsb_first = v.lsb;
    miso_drv = slave_bit(v.slave, v.lsb, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " sclk idle"}, sclk, v.cpol);
    if (!v.cpha) check({tag, " first mosi"}, mosi, v.lsb ? v.tx[0] : v.tx[BITS-1]);
    prev_sclk = sclk;
    while (!done && cyc < 2000) begin
      if (busy) begin
        busy_cyc++;
        if (ss_n !== v.exp_ss) bad_ss++;
      end
      if (sclk !== prev_sclk) begin
        toggles++;
        if (cyc - last_tog != DIV) bad_int++;
        last_tog = cyc;
        sample_edge = v.cpha ? (toggles % 2 == 0) : (toggles % 2 == 1);
        if (sample_edge) begin
          mosi_word = v.lsb ? {mosi, mosi_word[BITS-1:1]} : {mosi_word[BITS-2:0], mosi};
          samples++;
          miso_drv = slave_bit(v.slave, v.lsb, samples);
        end
      end
      prev_sclk = sclk;
      @(negedge clk);
      cyc++;
    end
    check({tag, " done seen"}, done, 1'b1);
    check({tag, " busy cycles"}, busy_cyc, (2 * BITS + 2) * DIV);
    check({tag, " sclk toggles"}, toggles, 2 * BITS);
    check({tag, " half-period spacing errors"}, bad_int, 0);
    check({tag, " ss_n errors"}, bad_ss, 0);
    check({tag, " mosi word"}, mosi_word, v.tx);
    check({tag, " rx_data"}, rx_data, v.exp_rx);
    check({tag, " idle state"}, {busy, sclk, mosi, ss_n}, {1'b0, v.cpol, 1'b0, {NSS{1'b1}}});
    @(negedge clk);
    check({tag, " done width"}, done, 1'b0);
    check({tag, " rx_data hold"}, rx_data, v.exp_rx);
  endtask

  task automatic wait_done(output int seen_cyc);
    seen_cyc = 0;
    while (!done && seen_cyc < 2000) begin
      @(negedge clk);
      seen_cyc++;
    end
  endtask

  vec_t tbl[$];
  vec_t rv;
  int   ndone, wc, toggles;
  logic prev;

  initial begin
    rst = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; cs_sel = '0; tx_data = '0;
    lsb_first = 1'b0; loop_mode = 1'b0; miso_drv = 1'b0;
    repeat (3) @(negedge clk);
    check("reset sclk", sclk, 1'b0);
    check("reset mosi", mosi, 1'b0);
    check("reset ss_n", ss_n, {NSS{1'b1}});
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset rx_data", rx_data, '0);
    rst = 1'b0;

    // Directed vectors: basic mode 0, mode 3 with miso high, out-of-range select.
    rv = mk(8'hA5, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 8'h00);
    rv.exp_rx = 8'hA5; rv.exp_ss = 4'b1101;
    tbl.push_back(rv);
    rv = mk(8'h3C, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 8'hFF);
    rv.exp_rx = 8'hFF; rv.exp_ss = 4'b1110;
    tbl.push_back(rv);
    rv = mk(8'h5A, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 8'h00);
    rv.exp_ss = 4'b1111;
    tbl.push_back(rv);
    tbl.push_back(mk(8'h96, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 8'h6B));
    tbl.push_back(mk(8'h00, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 8'h81));
`ifdef SPI_LSB_FIRST_EN
    rv = mk(8'h01, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 8'h00);
    rv.exp_rx = 8'h01;
    tbl.push_back(rv);
    tbl.push_back(mk(8'hC4, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 8'h2D));
`endif
    for (int i = 0; i < 20; i++) begin
      tbl.push_back(mk(BITS'($urandom), 1'($urandom), 1'($urandom), CSW'($urandom_range(0, 7)),
                       1'($urandom),
`ifdef SPI_LSB_FIRST_EN
                       1'($urandom),
`else
                       1'b0,
`endif
                       BITS'($urandom)));
    end
    foreach (tbl[i]) run_frame(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back: start held high, second frame accepted in the done cycle.
    @(negedge clk);
    tx_data = 8'h01; cpol = 1'b0; cpha = 1'b0; cs_sel = 3'd0; loop_mode = 1'b1; lsb_first = 1'b0;
    start = 1'b1;
    ndone = 0;
    @(negedge clk);
    wait_done(wc);
    if (done) ndone++;
    check("b2b first rx", rx_data, 8'h01);
    tx_data = 8'h80;
    @(negedge clk);
    check("b2b second setup busy", busy, 1'b1);
    check("b2b ss_n", ss_n, 4'b1110);
    start = 1'b0;
    wait_done(wc);
    if (done) ndone++;
    check("b2b second rx", rx_data, 8'h80);
    check("b2b done count", ndone, 2);
    @(negedge clk);
    check("b2b idle after", busy, 1'b0);

    // Abort: reset after three SCLK periods with cpol=1.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tx_data = 8'hC3; cpol = 1'b1; cpha = 1'b0; cs_sel = 3'd2; loop_mode = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    toggles = 0; wc = 0; prev = sclk;
    while (toggles < 6 && wc < 500) begin
      @(negedge clk);
      wc++;
      if (sclk !== prev) toggles++;
      prev = sclk;
    end
    check("abort reached 3 periods", toggles, 6);
    rst = 1'b1;
    #1;
    check("abort ss_n", ss_n, 4'b1111);
    check("abort sclk", sclk, 1'b0);
    check("abort busy", busy, 1'b0);
    check("abort rx_data", rx_data, '0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort no done", ndone, 0);
    check("abort stays idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_master_mc.md
SPI_MASTER_MC -- requirements
Module: spi_master_mc

Interface
REQ-001 SHALL have parameter BITS, default 8, frame width in bits (range 2..32).
REQ-002 SHALL have parameter NSS, default 4, number of slave-select lines (range 1..8).
REQ-003 SHALL have parameter DIV, default 2, clk cycles per SCLK half-period (range 1..255).
REQ-004 SHALL have ports: clk in 1 system clock; rst in 1 async active-high reset.
REQ-005 SHALL have ports: start in 1 transfer request; cpol in 1 clock polarity; cpha in 1 clock phase; cs_sel in clogb2(NSS) target slave index.
REQ-006 SHALL have ports: tx_data in BITS frame to send; miso in 1 serial input.
REQ-007 SHALL have ports: sclk out 1; mosi out 1; ss_n out NSS active-low selects; busy out 1; done out 1 one-cycle completion pulse; rx_data out BITS received frame.
REQ-008 Reset is asynchronous, active-high, on port rst; single clock clk; all state registers on posedge clk/posedge rst.

Function
REQ-009 SHALL sample start, cpol, cpha, cs_sel, tx_data only in IDLE when start=1; start while busy=1 SHALL be ignored.
REQ-010 SHALL implement FSM states IDLE, SETUP, XFER, HOLD; IDLE->SETUP on accepted start; SETUP->XFER after DIV cycles; XFER->HOLD after 2*BITS half-periods; HOLD->IDLE after DIV cycles.
REQ-011 busy SHALL be 1 in SETUP, XFER, HOLD; 0 in IDLE.
REQ-012 ss_n[cs_sel] SHALL be 0 from SETUP through HOLD inclusive; all other ss_n bits 1 at all times.
REQ-013 cs_sel >= NSS SHALL run the transfer with all ss_n bits held 1.
REQ-014 sclk SHALL idle at latched cpol and toggle every DIV clk cycles in XFER only, giving exactly BITS full SCLK periods.
REQ-015 cpha=0: mosi SHALL present bit at SETUP entry and shift on trailing edges; miso sampled on leading edges. cpha=1: mosi shifts on leading edges, miso sampled on trailing edges.
REQ-016 Default bit order SHALL be MSB first; mosi SHALL be 0 in IDLE.
REQ-017 done SHALL pulse 1 for exactly one cycle on HOLD->IDLE; rx_data SHALL update in that same cycle and hold until next done.
REQ-018 start asserted in the done cycle SHALL be accepted (back-to-back), next SETUP beginning the following cycle.
REQ-019 Bit counter SHALL be clogb2(BITS)+1 wide and SHALL not wrap within a frame.

Reset
REQ-020 On rst: FSM=IDLE, sclk=0, mosi=0, ss_n=all 1, busy=0, done=0, rx_data=0, latched cpol=0, counters=0.
REQ-021 rst asserted mid-transfer SHALL abort immediately with no done pulse and rx_data unchanged from 0.

Configuration
REQ-022 Macro SPI_LSB_FIRST_EN defined: add input lsb_first (1 bit), latched with start; lsb_first=1 shifts LSB first on both mosi and rx_data assembly.
REQ-023 Macro SPI_LSB_FIRST_EN undefined: port absent, MSB-first only.

Structure
REQ-024 Package spi_pkg SHALL hold FSM state encoding constants and clogb2 function; shared with existing SPI blocks.
REQ-025 Sub-module spi_clkgen SHALL produce the DIV half-period tick and leading/trailing edge strobes, enabled only in XFER.

Verification
REQ-026 BITS=8, DIV=2, cpol=0, cpha=0, cs_sel=1, tx_data=8'hA5, miso loopback from mosi -> ss_n=4'b1101 during transfer, mosi serial 1010_0101, rx_data=8'hA5, done once, 8 sclk periods of 4 clk.
REQ-027 cpol=1, cpha=1, tx_data=8'h3C, miso tied 1 -> sclk idles 1, rx_data=8'hFF, mosi bits 0011_1100.
REQ-028 start held 1 continuously with tx_data 8'h01 then 8'h80 -> two back-to-back frames, second SETUP one cycle after first done, two done pulses.
REQ-029 rst pulsed after 3 sclk periods -> ss_n=4'b1111, sclk=0, busy=0 within same cycle; no done; rx_data=0.
REQ-030 cs_sel=5 with NSS=4 -> ss_n stays 4'b1111, full frame timing, done pulses once.
REQ-031 SPI_LSB_FIRST_EN defined, lsb_first=1, tx_data=8'h01, loopback -> mosi first bit 1, rx_data=8'h01.
